// File: rtl/fp_mantissa_align_if.sv
`default_nettype none
// ============================================================================
//  Module      : fp_mantissa_align_if
//  Description : Input-vector / output-beat handshake bundle for
//                fp_mantissa_align. The slave modport is the aligner itself;
//                the master modport is the upstream compare stage together
//                with the downstream macro.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fp_mantissa_align_if #(
  parameter int MACRO_DATA_WIDTH = 128,
  parameter int LANES            = 16,
  parameter int EXP_WIDTH        = 4,
  parameter int FP_WIDTH         = 8,
  parameter int OUT_WIDTH        = 8,
  parameter int BEAT_W           = 3
);
  // Upstream side: one full FP vector per transfer
  logic                                  in_valid;
  logic                                  in_ready;
  logic [FP_WIDTH*MACRO_DATA_WIDTH-1:0]  fp_data_in;
  logic [EXP_WIDTH*MACRO_DATA_WIDTH-1:0] shift_data_in;
  logic [EXP_WIDTH-1:0]                  exp_max_in;

  // Downstream side: LANES aligned lanes per beat
  logic                                  out_valid;
  logic                                  out_ready;
  logic [OUT_WIDTH*LANES-1:0]            align_data_out;
  logic [EXP_WIDTH-1:0]                  exp_max_out;
  logic [BEAT_W-1:0]                     beat_idx_out;
  logic                                  out_last;

  modport slave (
    input  in_valid, fp_data_in, shift_data_in, exp_max_in, out_ready,
    output in_ready, out_valid, align_data_out, exp_max_out, beat_idx_out, out_last
  );

  modport master (
    output in_valid, fp_data_in, shift_data_in, exp_max_in, out_ready,
    input  in_ready, out_valid, align_data_out, exp_max_out, beat_idx_out, out_last
  );
endinterface
`default_nettype wire

// File: rtl/fp_mantissa_align.sv
`default_nettype none
// ============================================================================
//  Module      : fp_mantissa_align
//  Description : Captures one FP vector with its per-lane shift amounts and
//                block exponent, restores hidden bits, right-aligns every
//                mantissa to the shared exponent, converts to two's complement
//                and streams the result out in LANES-wide beats.
//  Options     : FP_ALIGN_ROUND_EN - round half-up on the aligned magnitude
//                (saturating); when undefined the magnitude is truncated.
//  Revision    : 1.0 - initial release
// ============================================================================
module fp_mantissa_align #(
  parameter int MACRO_DATA_WIDTH = 128,
  parameter int LANES            = 16,
  parameter int EXP_WIDTH        = 4,
  parameter int MANTISSA_WIDTH   = 3,
  parameter int SIGN_WIDTH       = 1,
  parameter int FP_WIDTH         = 8,
  parameter int GUARD_BITS       = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  fp_mantissa_align_if.slave   bus
);

  localparam int MAG_WIDTH    = MANTISSA_WIDTH + 1 + GUARD_BITS;
  localparam int OUT_WIDTH    = MAG_WIDTH + 1;
  localparam int NUM_BEATS    = MACRO_DATA_WIDTH / LANES;
  localparam int BEAT_W       = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam int BEAT_FP_BITS = LANES * FP_WIDTH;
  localparam int BEAT_SH_BITS = LANES * EXP_WIDTH;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [BEAT_W-1:0]       beat_q, beat_d;
  // Captured vector stored beat-sliced so the beat counter selects a slice directly
  logic [BEAT_FP_BITS-1:0] fp_q    [NUM_BEATS];
  logic [BEAT_FP_BITS-1:0] fp_d    [NUM_BEATS];
  logic [BEAT_SH_BITS-1:0] shift_q [NUM_BEATS];
  logic [BEAT_SH_BITS-1:0] shift_d [NUM_BEATS];
  logic [EXP_WIDTH-1:0]    exp_max_q, exp_max_d;

  logic                        in_ready;
  logic                        out_valid;
  logic                        accept;
  logic                        beat_done;
  logic                        last_beat;
  logic [LANES*OUT_WIDTH-1:0]  align_beat;

  // Aligns one lane: hidden bit restore, guard extension, right shift, sign apply
  function automatic logic [OUT_WIDTH-1:0] align_lane(
    input logic [FP_WIDTH-1:0]  lane,
    input logic [EXP_WIDTH-1:0] sh
  );
    logic [SIGN_WIDTH-1:0]     sgn;
    logic [EXP_WIDTH-1:0]      ex;
    logic [MANTISSA_WIDTH-1:0] mant;
    logic [MAG_WIDTH-1:0]      mag0;
    logic [MAG_WIDTH-1:0]      mag;
    logic [OUT_WIDTH-1:0]      ext;
`ifdef FP_ALIGN_ROUND_EN
    logic [MAG_WIDTH-1:0]      part;
    logic [MAG_WIDTH:0]        sum;
`endif
    {sgn, ex, mant} = lane;
    // Exponent zero is a denormal: no implicit leading one
    mag0 = {(|ex), mant, {GUARD_BITS{1'b0}}};
`ifdef FP_ALIGN_ROUND_EN
    part = '0;
    sum  = '0;
    if (int'(sh) > MAG_WIDTH) begin
      mag = '0;
    end else if (sh == '0) begin
      mag = mag0;
    end else begin
      // Shift one place short so the first discarded bit lands in part[0]
      part = mag0 >> (sh - 1'b1);
      sum  = {1'b0, part >> 1} + {{MAG_WIDTH{1'b0}}, part[0]};
      mag  = sum[MAG_WIDTH] ? {MAG_WIDTH{1'b1}} : sum[MAG_WIDTH-1:0];
    end
`else
    mag = (int'(sh) >= MAG_WIDTH) ? '0 : (mag0 >> sh);
`endif
    ext = {1'b0, mag};
    // Negating a zero magnitude yields zero, so no negative-zero code escapes
    return sgn[SIGN_WIDTH-1] ? (-ext) : ext;
  endfunction

  // Reset forces both handshake outputs low during the reset cycle itself
  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == BUSY) && !rst;
  assign accept    = bus.in_valid && in_ready;
  assign beat_done = out_valid && bus.out_ready;
  assign last_beat = (beat_q == BEAT_W'(NUM_BEATS - 1));

  // Next-state: capture on acceptance, advance beat on each output handshake
  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    fp_d      = fp_q;
    shift_d   = shift_q;
    exp_max_d = exp_max_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          for (int b = 0; b < NUM_BEATS; b++) begin
            fp_d[b]    = bus.fp_data_in[b*BEAT_FP_BITS +: BEAT_FP_BITS];
            shift_d[b] = bus.shift_data_in[b*BEAT_SH_BITS +: BEAT_SH_BITS];
          end
          exp_max_d = bus.exp_max_in;
          beat_d    = '0;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        if (beat_done) begin
          if (last_beat) begin
            beat_d  = '0;
            state_d = IDLE;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, beat counter and capture registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      beat_q    <= '0;
      fp_q      <= '{default: '0};
      shift_q   <= '{default: '0};
      exp_max_q <= '0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      fp_q      <= fp_d;
      shift_q   <= shift_d;
      exp_max_q <= exp_max_d;
    end
  end

  // Per-lane alignment of the beat currently selected by the beat counter
  always_comb begin
    align_beat = '0;
    for (int l = 0; l < LANES; l++) begin
      align_beat[l*OUT_WIDTH +: OUT_WIDTH] =
        align_lane(fp_q[beat_q][l*FP_WIDTH +: FP_WIDTH],
                   shift_q[beat_q][l*EXP_WIDTH +: EXP_WIDTH]);
    end
  end

  assign bus.in_ready       = in_ready;
  assign bus.out_valid      = out_valid;
  assign bus.align_data_out = out_valid ? align_beat : '0;
  assign bus.exp_max_out    = exp_max_q;
  assign bus.beat_idx_out   = out_valid ? beat_q : '0;
  assign bus.out_last       = out_valid && last_beat;

endmodule
`default_nettype wire

// File: tb/tb_fp_mantissa_align.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fp_mantissa_align
//  Description : Self-checking bench for fp_mantissa_align. Expected lanes come
//                from an arithmetic model (integer divide by a power of two).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_mantissa_align;

  localparam int NL = 128;
  localparam int LN = 16;
  localparam int NB = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fp_mantissa_align_if #(
    .MACRO_DATA_WIDTH(NL), .LANES(LN), .EXP_WIDTH(4),
    .FP_WIDTH(8), .OUT_WIDTH(8), .BEAT_W(3)
  ) bus ();

  fp_mantissa_align #(
    .MACRO_DATA_WIDTH(NL), .LANES(LN), .EXP_WIDTH(4), .MANTISSA_WIDTH(3),
    .SIGN_WIDTH(1), .FP_WIDTH(8), .GUARD_BITS(3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] vfp [NL];
  logic [3:0] vsh [NL];
  logic [3:0] vexp;

  // Value of a lane: (hidden.mant) scaled by 8 guard positions, divided by 2^shift
  function automatic logic [7:0] model_lane(input logic [7:0] fp, input logic [3:0] sh);
    int e, m, mag0, dv, mag;
    logic [7:0] r;
    e    = int'(fp[6:3]);
    m    = int'(fp[2:0]);
    mag0 = (((e != 0) ? 8 : 0) + m) * 8;
    dv   = 2 ** int'(sh);
`ifdef FP_ALIGN_ROUND_EN
    mag = (mag0 + dv / 2) / dv;
    if (mag > 127) mag = 127;
`else
    mag = mag0 / dv;
`endif
    r = 8'(mag);
    if (fp[7]) r = 8'(0 - mag);
    return r;
  endfunction

  function automatic logic [LN*8-1:0] model_beat(input int b);
    logic [LN*8-1:0] v;
    v = '0;
    for (int l = 0; l < LN; l++) v[l*8 +: 8] = model_lane(vfp[b*LN + l], vsh[b*LN + l]);
    return v;
  endfunction

  task automatic load_inputs();
    for (int i = 0; i < NL; i++) begin
      bus.fp_data_in[i*8 +: 8]    = vfp[i];
      bus.shift_data_in[i*4 +: 4] = vsh[i];
    end
    bus.exp_max_in = vexp;
  endtask

  task automatic fill_random();
    for (int i = 0; i < NL; i++) begin
      vfp[i] = 8'($urandom);
      vsh[i] = 4'($urandom_range(0, 15));
    end
    vexp = 4'($urandom);
  endtask

  // Offer the stored vector until accepted; leaves time at #1 after the accepting edge
  task automatic push_vector(output bit ok);
    ok = 1'b0;
    load_inputs();
    bus.in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (bus.in_ready) begin
        @(posedge clk); #1;
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
  endtask

  // Consume beats until the last one has been handed over
  task automatic drain(output bit ok);
    ok = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (bus.out_valid && bus.out_last) begin
        @(posedge clk); #1;
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.align_data_out !== '0 || bus.exp_max_out !== 4'h0) begin
      errors++;
      $display("FAIL reset_outputs: out_valid=%b align=%h exp_max=%h, required 0/0/0",
               bus.out_valid, bus.align_data_out, bus.exp_max_out);
    end
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_ready: got %b, required 0 during reset", bus.in_ready);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.beat_idx_out !== 3'd0 ||
        bus.out_last !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: in_ready=%b out_valid=%b idx=%0d last=%b, required 1/0/0/0",
               bus.in_ready, bus.out_valid, bus.beat_idx_out, bus.out_last);
    end
  endtask

  task automatic test_directed();
    logic [7:0] tl [9];
    logic [3:0] ts [9];
    logic [7:0] te [9];
    bit ok;
    tl[0] = 8'b0_0111_010; ts[0] = 4'd0;
    tl[1] = 8'b0_0111_010; ts[1] = 4'd2;
    tl[2] = 8'b1_0101_010; ts[2] = 4'd2;
    tl[3] = 8'b1_0101_010; ts[3] = 4'd7;
    tl[4] = 8'b1_0000_000; ts[4] = 4'd0;
    tl[5] = 8'b0_0000_011; ts[5] = 4'd0;
    tl[6] = 8'b0_0111_011; ts[6] = 4'd4;
    tl[7] = 8'b0_0111_011; ts[7] = 4'd7;
    tl[8] = 8'b0_0111_111; ts[8] = 4'd7;
`ifdef FP_ALIGN_ROUND_EN
    te[0] = 8'd80; te[1] = 8'd20; te[2] = 8'hEC; te[3] = 8'hFF; te[4] = 8'h00;
    te[5] = 8'd24; te[6] = 8'd6;  te[7] = 8'd1;  te[8] = 8'd1;
`else
    te[0] = 8'd80; te[1] = 8'd20; te[2] = 8'hEC; te[3] = 8'h00; te[4] = 8'h00;
    te[5] = 8'd24; te[6] = 8'd5;  te[7] = 8'd0;  te[8] = 8'd0;
`endif
    for (int k = 0; k < 9; k++) begin
      fill_random();
      vfp[0] = tl[k];
      vsh[0] = ts[k];
      vexp   = 4'd7;
      push_vector(ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL directed_accept[%0d]: vector not accepted within bound", k);
        continue;
      end
      checks++;
      if (bus.out_valid !== 1'b1 || bus.align_data_out[7:0] !== te[k]) begin
        errors++;
        $display("FAIL directed_lane0[%0d]: lane=%b shift=%0d got %h (valid=%b), required %h",
                 k, tl[k], ts[k], bus.align_data_out[7:0], bus.out_valid, te[k]);
      end
      checks++;
      if (bus.exp_max_out !== 4'd7) begin
        errors++;
        $display("FAIL directed_exp_max[%0d]: got %0d, required 7", k, bus.exp_max_out);
      end
      drain(ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL directed_drain[%0d]: last beat not seen within bound", k);
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [LN*8-1:0] snap;
    logic [LN*8-1:0] expv;
    for (int i = 0; i < NL; i++) begin
      vfp[i] = {1'($urandom), 4'($urandom_range(1, 15)), 3'(i % 8)};
      vsh[i] = 4'(i % 8);
    end
    vexp = 4'hB;
    push_vector(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL bp_accept: vector not accepted within bound");
      return;
    end
    for (int b = 0; b < NB; b++) begin
      expv = model_beat(b);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.beat_idx_out !== 3'(b) ||
          bus.out_last !== (b == NB - 1) || bus.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_framing[%0d]: valid=%b idx=%0d last=%b in_ready=%b, required 1/%0d/%b/0",
                 b, bus.out_valid, bus.beat_idx_out, bus.out_last, bus.in_ready, b, (b == NB - 1));
      end
      checks++;
      if (bus.align_data_out !== expv) begin
        errors++;
        $display("FAIL bp_data[%0d]: got %h, required %h", b, bus.align_data_out, expv);
      end
      if (b == 2) begin
        bus.out_ready = 1'b0;
        snap = bus.align_data_out;
        for (int s = 0; s < 3; s++) begin
          @(posedge clk); #1;
          checks++;
          if (bus.out_valid !== 1'b1 || bus.beat_idx_out !== 3'd2 || bus.align_data_out !== snap) begin
            errors++;
            $display("FAIL bp_stall[%0d]: valid=%b idx=%0d data=%h, required 1/2/%h",
                     s, bus.out_valid, bus.beat_idx_out, bus.align_data_out, snap);
          end
        end
      end
      if (b == 3) begin
        bus.exp_max_in = 4'h3;
        bus.in_valid   = 1'b1;
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      if (b == 5) bus.in_valid = 1'b0;
    end
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.exp_max_out !== 4'hB) begin
      errors++;
      $display("FAIL bp_end: in_ready=%b out_valid=%b exp_max=%h, required 1/0/B",
               bus.in_ready, bus.out_valid, bus.exp_max_out);
    end
  endtask

  task automatic test_reset_midstream();
    bit ok;
    logic [LN*8-1:0] expv;
    fill_random();
    push_vector(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL mid_accept: vector not accepted within bound");
      return;
    end
    bus.out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    checks++;
    if (bus.beat_idx_out !== 3'd4) begin
      errors++;
      $display("FAIL mid_beat4: idx=%0d, required 4", bus.beat_idx_out);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.align_data_out !== '0 || bus.exp_max_out !== 4'h0) begin
      errors++;
      $display("FAIL mid_reset: valid=%b data=%h exp_max=%h, required 0/0/0",
               bus.out_valid, bus.align_data_out, bus.exp_max_out);
    end
    rst = 1'b0;
    #1;
    fill_random();
    push_vector(ok);
    expv = model_beat(0);
    checks++;
    if (!ok || bus.out_valid !== 1'b1 || bus.beat_idx_out !== 3'd0 || bus.align_data_out !== expv) begin
      errors++;
      $display("FAIL mid_restart: ok=%b valid=%b idx=%0d data=%h, required 1/1/0/%h",
               ok, bus.out_valid, bus.beat_idx_out, bus.align_data_out, expv);
    end
    drain(ok);
  endtask

  task automatic test_random();
    bit ok;
    int eb;
    logic [LN*8-1:0] expv;
    for (int v = 0; v < 8; v++) begin
      fill_random();
      push_vector(ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL rnd_accept[%0d]: vector not accepted within bound", v);
        continue;
      end
      eb = 0;
      for (int c = 0; c < 200 && eb < NB; c++) begin
        bus.out_ready = 1'($urandom_range(0, 1));
        if (bus.out_valid && bus.out_ready) begin
          expv = model_beat(eb);
          checks++;
          if (bus.beat_idx_out !== 3'(eb) || bus.out_last !== (eb == NB - 1) ||
              bus.align_data_out !== expv || bus.exp_max_out !== vexp) begin
            errors++;
            $display("FAIL rnd_beat[%0d.%0d]: idx=%0d last=%b data=%h exp=%h, required %0d/%b/%h/%h",
                     v, eb, bus.beat_idx_out, bus.out_last, bus.align_data_out, bus.exp_max_out,
                     eb, (eb == NB - 1), expv, vexp);
          end
          eb++;
        end
        @(posedge clk); #1;
      end
      bus.out_ready = 1'b0;
      checks++;
      if (eb != NB || bus.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL rnd_count[%0d]: beats=%0d out_valid=%b, required %0d/0", v, eb, bus.out_valid, NB);
      end
    end
  endtask

  initial begin
    bus.in_valid      = 1'b0;
    bus.out_ready     = 1'b0;
    bus.fp_data_in    = '0;
    bus.shift_data_in = '0;
    bus.exp_max_in    = '0;
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_midstream();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fp_mantissa_align.md
Name: fp_mantissa_align

Overview:
- Stage directly downstream of the exponent compare/shift-amount stage in the input path.
- Accepts one FP vector of MACRO_DATA_WIDTH lanes, with the per-lane right-shift amounts and the block max exponent from the compare stage.
- Restores hidden bits, right-aligns each mantissa to the shared exponent and converts it to two's complement.
- Streams the aligned block-floating-point result to the macro in LANES-wide beats under a valid/ready handshake.

Parameters:
- MACRO_DATA_WIDTH, 128: lanes per input vector.
- LANES, 16: lanes emitted per output beat. MACRO_DATA_WIDTH % LANES must be 0.
- EXP_WIDTH, 4: exponent and shift-amount width.
- MANTISSA_WIDTH, 3: stored mantissa bits.
- SIGN_WIDTH, 1: sign bits per lane.
- FP_WIDTH, 8: lane width, equal to SIGN_WIDTH + EXP_WIDTH + MANTISSA_WIDTH. Lane layout is {sign, exp, mant}.
- GUARD_BITS, 3: fractional guard bits appended below the mantissa.
- Derived:
  - MAG_WIDTH = MANTISSA_WIDTH + 1 + GUARD_BITS (7).
  - OUT_WIDTH = MAG_WIDTH + 1 (8).
  - NUM_BEATS = MACRO_DATA_WIDTH / LANES (8).

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input vector valid.
- in_ready  out  1  block can accept a vector.
- fp_data_in  in  FP_WIDTH*MACRO_DATA_WIDTH  raw FP lanes; lane i at [i*FP_WIDTH +: FP_WIDTH].
- shift_data_in  in  EXP_WIDTH*MACRO_DATA_WIDTH  per-lane shift, equal to exp_max - exp_i.
- exp_max_in  in  EXP_WIDTH  shared block exponent.
- out_valid  out  1  output beat valid.
- out_ready  in  1  consumer accepts beat.
- align_data_out  out  OUT_WIDTH*LANES  signed aligned lanes of the current beat.
- exp_max_out  out  EXP_WIDTH  block exponent of the vector being streamed.
- beat_idx_out  out  log2(NUM_BEATS), minimum 1  index of the current beat.
- out_last  out  1  current beat is beat NUM_BEATS-1.

Behaviour:
- States: IDLE and BUSY.
- Reset (synchronous, rst=1):
  - State goes to IDLE and beat counter to 0.
  - Capture registers and exp_max_out are cleared.
  - Outputs: out_valid=0, align_data_out=0, beat_idx_out=0, out_last=0, exp_max_out=0, in_ready=0 during the reset cycle, then 1.
  - Reset mid-stream abandons the vector with no further beats.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&in_ready: capture fp_data_in, shift_data_in and exp_max_in; clear the beat counter; go to BUSY.
- BUSY:
  - in_ready=0, out_valid=1.
  - Lanes for beat b are b*LANES .. b*LANES+LANES-1.
  - On out_valid&out_ready the beat counter increments.
  - On the handshake of beat NUM_BEATS-1, go to IDLE.
  - With out_ready=0, every output holds stable (no-drop, no-change rule).
- Latency and throughput:
  - Beat 0 is valid the cycle after input acceptance.
  - Minimum NUM_BEATS+1 cycles per vector: one IDLE bubble after the last beat, with no same-cycle re-accept.
- Per-lane arithmetic (combinational from captured registers and beat counter):
  - hidden = (exp != 0). Exponent 0 is a denormal and gets hidden=0.
  - mag0 = {hidden, mant, GUARD_BITS zeros}, MAG_WIDTH bits.
  - If shift >= MAG_WIDTH, mag = 0; otherwise mag = mag0 >> shift (logical shift).
  - align = sign ? -mag : mag, sign-extended to OUT_WIDTH.
  - A negative zero result is emitted as 0.
- When out_valid=0, align_data_out, out_last and beat_idx_out are driven 0.
- exp_max_out holds the captured exponent until the next acceptance.
- Shift inputs are used as given; they are not cross-checked against exp_max_in.

Optional Feature:
- Macro: FP_ALIGN_ROUND_EN.
- Defined: round half-up on magnitude.
  - The first bit shifted out is added to mag.
  - The result saturates at 2^MAG_WIDTH-1.
  - When shift >= MAG_WIDTH+1, mag = 0.
  - When shift == MAG_WIDTH, the round bit is mag0's MSB.
  - Rounding is applied before negation.
- Undefined: truncation exactly as in Behaviour, with no rounding logic synthesized.

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> out_valid=0, align_data_out=0, exp_max_out=0; in_ready=1 on the first cycle after rst drops.
- Single lane align: lane0 = 8'b0_0111_010, shift 0, exp_max 7 -> beat0 lane0 = 8'd80, exp_max_out=7. Same lane with shift 2 -> 8'd20.
- Sign and underflow:
  - lane0 = 8'b1_0101_010 with shift 2 -> 8'hEC (-20).
  - Shift 7 -> 8'h00.
  - Lane 8'b1_0000_000 with shift 0 -> 8'h00, never 8'h80.
- Denormal: lane = 8'b0_0000_011, shift 0 -> mag0 = 0011000 -> 8'd24.
- Backpressure and framing:
  - Vector of 128 lanes where lane i has mant=i%8 and shift=i%8.
  - Hold out_ready=0 for 3 cycles at beat 2 -> outputs stable.
  - Exactly 8 beats with beat_idx_out 0..7; out_last only on beat 7; in_ready=0 throughout; in_ready=1 the cycle after beat 7 handshake.
  - Assert in_valid during BUSY -> not accepted.
- Reset mid-stream: rst=1 at beat 4 -> out_valid=0 next cycle; a new vector is then accepted and restarts at beat 0.
- FP_ALIGN_ROUND_EN build only:
  - lane 8'b0_0111_011 (mag0 = 88), shift 4 -> 6 (truncation gives 5).
  - Shift 7 -> 1.
  - lane 8'b0_0111_111 (mag0 = 120), shift 7 -> 1.
